// File: rtl/db_cbf_ram_ctrl.sv
// db_cbf_ram_ctrl: access controller for the 64x16 deblocking CBF buffer.
// Packs per-TU flag nibbles into 4x4-granular words (read-modify-write for
// 4x4/8x8 TUs, plain writes for 16x16/32x32) and serves single-word reads
// to the boundary-strength stage. Reads always win over writes in IDLE.
module db_cbf_ram_ctrl #(
    parameter int FLAG_W = 4,
    parameter int ADR_W  = 6,
    parameter int DAT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_val_i,
    output logic              wr_rdy_o,
    input  logic [3:0]        wr_x_i,
    input  logic [3:0]        wr_y_i,
    input  logic [1:0]        wr_size_i,
    input  logic [FLAG_W-1:0] wr_flag_i,
    input  logic              rd_req_i,
    input  logic [ADR_W-1:0]  rd_adr_i,
    output logic              rd_ack_o,
    output logic              rd_val_o,
    output logic [DAT_W-1:0]  rd_dat_o,
    output logic [ADR_W-1:0]  ram_adr_o,
    output logic              ram_cen_o,
    output logic              ram_wen_o,
    output logic [DAT_W-1:0]  ram_wdat_o,
    input  logic [DAT_W-1:0]  ram_rdat_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_MOD  = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    // Force the TU origin onto its own size grid.
    function automatic logic [3:0] align_pos(input logic [3:0] p, input logic [1:0] sz);
        case (sz)
            2'd0:    return p;
            2'd1:    return {p[3:1], 1'b0};
            2'd2:    return {p[3:2], 2'b00};
            default: return {p[3], 3'b000};
        endcase
    endfunction

    // Index of the last word row touched by a TU of the given size.
    function automatic logic [2:0] last_row_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Merge new flags into an existing word: one nibble for 4x4, one byte for 8x8.
    function automatic logic [DAT_W-1:0] merge_word(input logic [DAT_W-1:0] old,
                                                    input logic [1:0]       sz,
                                                    input logic [1:0]       xl,
                                                    input logic [FLAG_W-1:0] f);
        logic [DAT_W-1:0] w;
        w = old;
        if (sz == 2'd0) begin
            w[{xl, 2'b00} +: FLAG_W] = f;
        end else if (xl[1]) begin
            w[15:8] = {f, f};
        end else begin
            w[7:0] = {f, f};
        end
        return w;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic              col_q, col_d;
    logic [3:0]        x_q, x_d;
    logic [3:0]        y_q, y_d;
    logic [1:0]        size_q, size_d;
    logic [FLAG_W-1:0] flag_q, flag_d;
    logic              rd_val_q;

    logic [3:0]        row_y;
    logic [1:0]        col_w;
    logic [ADR_W-1:0]  cur_adr;
    logic              last_row;
    logic              last_col;

    assign row_y    = y_q + {1'b0, row_q};
    assign col_w    = x_q[3:2] + {1'b0, col_q};
    assign cur_adr  = {row_y, col_w};
    assign last_row = (row_q == last_row_of(size_q));
    assign last_col = (size_q != 2'd3) || col_q;

    assign rd_val_o = rd_val_q;
    assign rd_dat_o = ram_rdat_i;

    // Next-state, handshake and RAM port decode.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        x_d        = x_q;
        y_d        = y_q;
        size_d     = size_q;
        flag_d     = flag_q;
        wr_rdy_o   = 1'b0;
        rd_ack_o   = 1'b0;
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_adr_o  = '0;
        ram_wdat_o = '0;
        case (state_q)
            S_IDLE: begin
                if (rd_req_i) begin
                    rd_ack_o  = 1'b1;
                    ram_cen_o = 1'b0;
                    ram_adr_o = rd_adr_i;
                end else begin
                    wr_rdy_o = 1'b1;
                    if (wr_val_i) begin
                        x_d     = align_pos(wr_x_i, wr_size_i);
                        y_d     = align_pos(wr_y_i, wr_size_i);
                        size_d  = wr_size_i;
                        flag_d  = wr_flag_i;
                        row_d   = 3'd0;
                        col_d   = 1'b0;
                        state_d = wr_size_i[1] ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                ram_cen_o = 1'b0;
                ram_adr_o = cur_adr;
                state_d   = S_MOD;
            end
            S_MOD: begin
                ram_cen_o  = 1'b0;
                ram_wen_o  = 1'b0;
                ram_adr_o  = cur_adr;
                ram_wdat_o = merge_word(ram_rdat_i, size_q, x_q[1:0], flag_q);
                if (last_row) begin
                    state_d = S_IDLE;
                end else begin
                    row_d   = row_q + 3'd1;
                    state_d = S_RD;
                end
            end
            default: begin
                ram_cen_o  = 1'b0;
                ram_wen_o  = 1'b0;
                ram_adr_o  = cur_adr;
                ram_wdat_o = {(DAT_W/FLAG_W){flag_q}};
                if (last_col) begin
                    col_d = 1'b0;
                    if (last_row) begin
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    col_d = 1'b1;
                end
            end
        endcase
    end

    // Control state: async reset drops any TU in flight and releases the RAM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            row_q    <= 3'd0;
            col_q    <= 1'b0;
            rd_val_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rd_val_q <= rd_ack_o;
        end
    end

    // Captured TU parameters; only meaningful once a write has been accepted.
    always_ff @(posedge clk) begin
        x_q    <= x_d;
        y_q    <= y_d;
        size_q <= size_d;
        flag_q <= flag_d;
    end

endmodule

// File: tb/tb_db_cbf_ram_ctrl.sv
// Bench for db_cbf_ram_ctrl: RAM model, cell-level expected-content model,
// per-cycle compare process and directed TU/read sequences.
module tb_db_cbf_ram_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_val_i = 1'b0;
    logic        wr_rdy_o;
    logic [3:0]  wr_x_i = '0;
    logic [3:0]  wr_y_i = '0;
    logic [1:0]  wr_size_i = '0;
    logic [3:0]  wr_flag_i = '0;
    logic        rd_req_i = 1'b0;
    logic [5:0]  rd_adr_i = '0;
    logic        rd_ack_o;
    logic        rd_val_o;
    logic [15:0] rd_dat_o;
    logic [5:0]  ram_adr_o;
    logic        ram_cen_o;
    logic        ram_wen_o;
    logic [15:0] ram_wdat_o;
    logic [15:0] ram_rdat = '0;

    db_cbf_ram_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_val_i   (wr_val_i),
        .wr_rdy_o   (wr_rdy_o),
        .wr_x_i     (wr_x_i),
        .wr_y_i     (wr_y_i),
        .wr_size_i  (wr_size_i),
        .wr_flag_i  (wr_flag_i),
        .rd_req_i   (rd_req_i),
        .rd_adr_i   (rd_adr_i),
        .rd_ack_o   (rd_ack_o),
        .rd_val_o   (rd_val_o),
        .rd_dat_o   (rd_dat_o),
        .ram_adr_o  (ram_adr_o),
        .ram_cen_o  (ram_cen_o),
        .ram_wen_o  (ram_wen_o),
        .ram_wdat_o (ram_wdat_o),
        .ram_rdat_i (ram_rdat)
    );

    always #5 clk = ~clk;

    // Single-port RAM behaviour: registered read data.
    logic [15:0] ram_mem [64];
    always @(posedge clk) begin
        if (!ram_cen_o) begin
            if (!ram_wen_o) ram_mem[ram_adr_o] <= ram_wdat_o;
            else            ram_rdat <= ram_mem[ram_adr_o];
        end
    end

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_mem [64];
    int          exp_a_q[$];
    logic [15:0] exp_d_q[$];
    int          wlog_a[$];
    logic [15:0] wlog_d[$];
    int          busy_left = 0;
    bit          rd_pend = 0;
    logic [15:0] rd_exp = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int tu_cycles(input int sz);
        case (sz)
            0:       return 2;
            1:       return 4;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    // Expected words for a TU, built cell by cell from the current content.
    task automatic model_accept(input int x, input int y, input int sz, input logic [3:0] f);
        int n, ax, ay, a;
        logic [15:0] w;
        n  = 1 << sz;
        ax = x - (x % n);
        ay = y - (y % n);
        for (int r = 0; r < n; r++) begin
            for (int wc = ax / 4; wc <= (ax + n - 1) / 4; wc++) begin
                a = (ay + r) * 4 + wc;
                w = exp_mem[a[5:0]];
                for (int c = ax; c < ax + n; c++)
                    if (c / 4 == wc) w[(c % 4) * 4 +: 4] = f;
                exp_a_q.push_back(a);
                exp_d_q.push_back(w);
            end
        end
        busy_left = tu_cycles(sz);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit exp_ack, exp_rdy;
        int a;
        logic [15:0] d;
        if (!rstn) begin
            exp_a_q.delete();
            exp_d_q.delete();
            busy_left = 0;
            rd_pend   = 0;
        end else begin
            chk("rd_val", 32'(rd_val_o), 32'(rd_pend));
            if (rd_pend) chk("rd_dat", 32'(rd_dat_o), 32'(rd_exp));
            exp_ack = (busy_left == 0) && rd_req_i;
            exp_rdy = (busy_left == 0) && !rd_req_i;
            chk("rd_ack", 32'(rd_ack_o), 32'(exp_ack));
            chk("wr_rdy", 32'(wr_rdy_o), 32'(exp_rdy));
            if (exp_ack) begin
                chk("rd_cen", 32'(ram_cen_o), 32'(0));
                chk("rd_wen", 32'(ram_wen_o), 32'(1));
                chk("rd_adr", 32'(ram_adr_o), 32'(rd_adr_i));
            end else if (busy_left == 0) begin
                chk("idle_cen", 32'(ram_cen_o), 32'(1));
            end
            if (!ram_cen_o && !ram_wen_o) begin
                wlog_a.push_back(int'(ram_adr_o));
                wlog_d.push_back(ram_wdat_o);
                if (exp_a_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: adr %0d data %0h", ram_adr_o, ram_wdat_o);
                end else begin
                    a = exp_a_q.pop_front();
                    d = exp_d_q.pop_front();
                    chk("wr_adr", 32'(ram_adr_o), 32'(a));
                    chk("wr_dat", 32'(ram_wdat_o), 32'(d));
                    exp_mem[a[5:0]] = d;
                end
            end
            rd_pend = exp_ack;
            rd_exp  = exp_mem[rd_adr_i];
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) chk("writes_left", 32'(exp_a_q.size()), 32'(0));
            end else if (exp_rdy && wr_val_i) begin
                model_accept(int'(wr_x_i), int'(wr_y_i), int'(wr_size_i), wr_flag_i);
            end
        end
    end

    task automatic wr_tu(input int x, input int y, input int sz, input logic [3:0] f, output int busy);
        bit ok;
        @(posedge clk); #1;
        wr_val_i = 1'b1; wr_x_i = 4'(x); wr_y_i = 4'(y); wr_size_i = 2'(sz); wr_flag_i = f;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (wr_rdy_o) ok = 1;
        end
        chk("wr_accept", 32'(ok), 32'(1));
        @(posedge clk); #1;
        wr_val_i = 1'b0;
        busy = 0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (wr_rdy_o) ok = 1; else busy++;
        end
        chk("wr_done", 32'(ok), 32'(1));
    endtask

    task automatic rd_word(input int a, input logic [15:0] expd);
        @(posedge clk); #1;
        rd_req_i = 1'b1; rd_adr_i = 6'(a);
        @(negedge clk);
        chk("rd_ack_lit", 32'(rd_ack_o), 32'(1));
        @(posedge clk); #1;
        rd_req_i = 1'b0;
        @(negedge clk);
        chk("rd_val_lit", 32'(rd_val_o), 32'(1));
        chk("rd_dat_lit", 32'(rd_dat_o), 32'(expd));
    endtask

    task automatic chk_log(input string nm, input int a, input logic [15:0] d, input int idx);
        if (idx < wlog_a.size()) begin
            chk({nm, "_adr"}, 32'(wlog_a[idx]), 32'(a));
            chk({nm, "_dat"}, 32'(wlog_d[idx]), 32'(d));
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: write %0d missing", nm, idx);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy, cnt;
        bit ok;
        int a32 [16] = '{0, 1, 4, 5, 8, 9, 12, 13, 16, 17, 20, 21, 24, 25, 28, 29};
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = '0;
            exp_mem[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cen", 32'(ram_cen_o), 32'(1));
        chk("rst_wen", 32'(ram_wen_o), 32'(1));
        chk("rst_rd_val", 32'(rd_val_o), 32'(0));
        chk("rst_wr_rdy", 32'(wr_rdy_o), 32'(1));
        chk("rst_rd_ack", 32'(rd_ack_o), 32'(0));
        chk("rst_adr", 32'(ram_adr_o), 32'(0));
        chk("rst_wdat", 32'(ram_wdat_o), 32'(0));
        @(posedge clk); #1;
        rstn = 1'b1;

        // 32x32 at (0,0), flag B
        wlog_a.delete(); wlog_d.delete();
        wr_tu(0, 0, 3, 4'hB, busy);
        chk("busy_32", 32'(busy), 32'(16));
        chk("nwr_32", 32'(wlog_a.size()), 32'(16));
        for (int i = 0; i < 16; i++) chk_log("w32", a32[i], 16'hBBBB, i);
        rd_word(5, 16'hBBBB);

        // 16x16 preload then 4x4 RMW
        wlog_a.delete(); wlog_d.delete();
        wr_tu(0, 0, 2, 4'h0, busy);
        chk("busy_16", 32'(busy), 32'(4));
        for (int i = 0; i < 4; i++) chk_log("w16", i * 4, 16'h0000, i);
        wlog_a.delete(); wlog_d.delete();
        wr_tu(2, 0, 0, 4'h5, busy);
        chk("busy_4", 32'(busy), 32'(2));
        chk("nwr_4", 32'(wlog_a.size()), 32'(1));
        chk_log("w4", 0, 16'h0500, 0);

        // 8x8 RMW over BBBB words, then a misaligned 8x8 on the same words
        wlog_a.delete(); wlog_d.delete();
        wr_tu(6, 2, 1, 4'h3, busy);
        chk("busy_8", 32'(busy), 32'(4));
        chk_log("w8a", 9, 16'h33BB, 0);
        chk_log("w8b", 13, 16'h33BB, 1);
        wlog_a.delete(); wlog_d.delete();
        wr_tu(7, 3, 1, 4'hA, busy);
        chk_log("w8m_a", 9, 16'hAABB, 0);
        chk_log("w8m_b", 13, 16'hAABB, 1);

        // Misaligned 16x16 and corner 4x4
        wlog_a.delete(); wlog_d.delete();
        wr_tu(5, 6, 2, 4'hC, busy);
        for (int i = 0; i < 4; i++) chk_log("w16m", 17 + i * 4, 16'hCCCC, i);
        wlog_a.delete(); wlog_d.delete();
        wr_tu(15, 15, 0, 4'hF, busy);
        chk_log("w4c", 63, 16'hF000, 0);

        // Arbitration: simultaneous read and write
        @(posedge clk); #1;
        rd_req_i = 1'b1; rd_adr_i = 6'd0;
        wr_val_i = 1'b1; wr_x_i = 4'd1; wr_y_i = 4'd0; wr_size_i = 2'd0; wr_flag_i = 4'h9;
        @(negedge clk);
        chk("arb_ack", 32'(rd_ack_o), 32'(1));
        chk("arb_rdy", 32'(wr_rdy_o), 32'(0));
        @(posedge clk); #1;
        rd_req_i = 1'b0;
        @(negedge clk);
        chk("arb_rdy2", 32'(wr_rdy_o), 32'(1));
        chk("arb_rdat", 32'(rd_dat_o), 32'(16'h0500));
        @(posedge clk); #1;
        wr_val_i = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (wr_rdy_o) ok = 1;
        end
        chk("arb_done", 32'(ok), 32'(1));
        rd_word(0, 16'h0590);

        // Read held off during a 32x32 write
        @(posedge clk); #1;
        wr_val_i = 1'b1; wr_x_i = 4'd8; wr_y_i = 4'd8; wr_size_i = 2'd3; wr_flag_i = 4'h7;
        @(negedge clk);
        chk("rdw_accept", 32'(wr_rdy_o), 32'(1));
        @(posedge clk); #1;
        wr_val_i = 1'b0; rd_req_i = 1'b1; rd_adr_i = 6'd34;
        cnt = 0; ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rd_ack_o) ok = 1; else cnt++;
        end
        chk("rdw_wait", 32'(cnt), 32'(16));
        @(posedge clk); #1;
        rd_req_i = 1'b0;
        @(negedge clk);
        chk("rdw_val", 32'(rd_val_o), 32'(1));
        chk("rdw_dat", 32'(rd_dat_o), 32'(16'h7777));

        // Reset after the 5th write of a 32x32
        wlog_a.delete(); wlog_d.delete();
        @(posedge clk); #1;
        wr_val_i = 1'b1; wr_x_i = 4'd0; wr_y_i = 4'd8; wr_size_i = 2'd3; wr_flag_i = 4'hE;
        @(negedge clk);
        chk("mid_accept", 32'(wr_rdy_o), 32'(1));
        @(posedge clk); #1;
        wr_val_i = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); #1;
            if (wlog_a.size() >= 5) ok = 1;
        end
        chk("mid_5wr", 32'(ok), 32'(1));
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("mid_cen", 32'(ram_cen_o), 32'(1));
        chk("mid_wen", 32'(ram_wen_o), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("mid_nwr", 32'(wlog_a.size()), 32'(5));
        @(negedge clk);
        chk("mid_rdy", 32'(wr_rdy_o), 32'(1));
        rd_word(40, 16'hEEEE);
        rd_word(41, 16'h0000);
        wlog_a.delete(); wlog_d.delete();
        wr_tu(3, 9, 0, 4'h6, busy);
        chk("post_busy", 32'(busy), 32'(2));
        chk_log("post_w", 36, 16'h6EEE, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/db_cbf_ram_ctrl.md
# db_cbf_ram_ctrl

Access controller for the deblocking CBF buffer (64 words x 16 bits, single-port, active-low CEN/WEN). Packs per-TU coded-block flags from the reconstruction side into 4x4-granular nibbles, using read-modify-write where a TU covers less than a full word. Also serves single-word reads to the boundary-strength stage. Sits directly upstream of the 64x16 CBF RAM and drives all of its ports.

## Interface
- FLAG_W, 4, flags per 4x4 block: [0] cbf_y, [1] cbf_cb, [2] cbf_cr, [3] intra (fixed)
- ADR_W, 6, RAM address width (fixed)
- DAT_W, 16, RAM word width (fixed)

- clk  in  1  sole clock, rising edge
- rstn  in  1  asynchronous reset, active low
- wr_val_i  in  1  TU flag-write request
- wr_rdy_o  out  1  write accepted when wr_val_i & wr_rdy_o
- wr_x_i  in  4  TU x position in 4x4 units (0..15)
- wr_y_i  in  4  TU y position in 4x4 units (0..15)
- wr_size_i  in  2  0:4x4, 1:8x8, 2:16x16, 3:32x32
- wr_flag_i  in  4  flag nibble applied to every covered 4x4
- rd_req_i  in  1  BS-stage read request
- rd_adr_i  in  6  word address to read
- rd_ack_o  out  1  read accepted this cycle
- rd_val_o  out  1  rd_dat_o valid
- rd_dat_o  out  16  read word (= ram_rdat_i)
- ram_adr_o  out  6  RAM address
- ram_cen_o  out  1  RAM chip enable, low active
- ram_wen_o  out  1  RAM write enable, low active
- ram_wdat_o  out  16  RAM write data
- ram_rdat_i  in  16  RAM read data, valid the cycle after a read

## Operation
- Word map: adr = y*4 + (x>>2); nibble n = bits [4n+3:4n] holds column 4*(adr%4)+n.
- Misaligned TU positions: low bits forced to zero (x,y aligned to size).
- FSM states: IDLE, RD, MOD, WR.
- IDLE, rd_req_i high: rd_ack_o=1, ram_cen_o=0, ram_wen_o=1, ram_adr_o=rd_adr_i (combinational). Reads win over writes.
- IDLE, wr_val_i high and rd_req_i low: wr_rdy_o=1. Capture x, y, size, flag; clear row/col counters.
  - size 0/1 -> RD.
  - size 2/3 -> WR.
- RD: issue read of current row word -> MOD.
- MOD: write ram_rdat_i merged with the new flags:
  - size 0: nibble x[1:0] replaced.
  - size 1: byte x[1] replaced with {flag,flag}.
  - Then next row -> RD; after last row -> IDLE.
- WR: write {4{flag}} to each covered word, row-major, col inner.
  - size 2: 4 rows x 1 word.
  - size 3: 8 rows x 2 words.
  - After last word -> IDLE.
- wr_rdy_o and rd_ack_o are 0 outside IDLE. Requests are held by the requester.
- Outside active access cycles: ram_cen_o=1, ram_wen_o=1.

## Timing
- Reset values:
  - state IDLE, rd_val_o=0.
  - ram_cen_o=1, ram_wen_o=1, ram_adr_o=0, ram_wdat_o=0.
  - wr_rdy_o = !rd_req_i, rd_ack_o = rd_req_i.
- Read latency: ack in cycle T; rd_val_o=1 and rd_dat_o valid in T+1.
  - Back-to-back reads are accepted every IDLE cycle.
- Write busy cycles after acceptance, returning to IDLE the cycle after:
  - 4x4: 2 cycles (RD, MOD).
  - 8x8: 4 cycles.
  - 16x16: 4 cycles.
  - 32x32: 16 cycles.
- Simultaneous rd_req_i and wr_val_i in IDLE: read acked; write waits until a cycle with rd_req_i low.
- rd_val_o is never asserted in MOD/WR cycles; a read issued in cycle T never collides with an RMW read.
- Reset mid-operation: FSM returns to IDLE asynchronously and ram_cen_o goes high immediately. Words already written remain; the rest of the TU is lost.

## Test plan
- Reset: rstn low with rd_req_i=0 -> ram_cen_o=1, ram_wen_o=1, rd_val_o=0, wr_rdy_o=1.
- 32x32 at (0,0), flag 4'hB -> 16 writes:
  - Addresses 0,1,4,5,...,28,29, each ram_wdat_o=16'hBBBB, wr_rdy_o low 16 cycles.
  - Then read adr 5 -> rd_val_o next cycle, rd_dat_o=16'hBBBB.
- 4x4 RMW:
  - Preload with 16x16 at (0,0), flag 0 -> writes 0x0000 to adr 0,4,8,12.
  - Then 4x4 at x=2,y=0, flag 4'h5 -> read adr 0, next cycle write adr 0 data 16'h0500.
- 8x8 at x=6,y=2, flag 4'h3 over words holding 16'hBBBB -> RMW at adr 9 then adr 13, each write 16'h33BB.
- Arbitration:
  - rd_req_i and wr_val_i both high in IDLE -> rd_ack_o=1, wr_rdy_o=0; write accepted next cycle after rd_req_i drops.
  - rd_req_i raised during a 32x32 write -> rd_ack_o held low until IDLE.
- Reset mid-write: rstn pulsed after 5th write of a 32x32 -> ram_cen_o=1 immediately, no further writes, next request accepted normally.
